// File: rtl/dmem_port_if.sv
// Lane request/response ports and data-memory command port shared by the dmem arbiter.
// The master side is the core/memory environment, the slave side is the arbiter.
interface dmem_port_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [2:0]  ldfmt0, ldfmt1;
  logic [1:0]  stfmt0, stfmt1;
  logic [63:0] addr0, addr1;
  logic [63:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        rsp_valid0, rsp_valid1;
  logic        rsp_err0, rsp_err1;
  logic [63:0] rsp_data;
  logic        mem_read_en, mem_write_en;
  logic [63:0] mem_addr, mem_wdata;
  logic [2:0]  load_format;
  logic [1:0]  store_format;
  logic [63:0] mem_rdata;

  modport master (
    output req0, req1, we0, we1, ldfmt0, ldfmt1, stfmt0, stfmt1,
           addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1, rsp_data,
           mem_read_en, mem_write_en, mem_addr, mem_wdata, load_format, store_format
  );

  modport slave (
    input  req0, req1, we0, we1, ldfmt0, ldfmt1, stfmt0, stfmt1,
           addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1, rsp_data,
           mem_read_en, mem_write_en, mem_addr, mem_wdata, load_format, store_format
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-lane arbiter for the single-ported data memory: one registered command per cycle,
// registered load return, out-of-range rejection and a saturating contention counter.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_LIMIT = 32'd4096,
  parameter int unsigned CNT_W      = 32'd16
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_port_if.slave       bus,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

  function automatic logic [3:0] access_size(input logic       we,
                                             input logic [2:0] ldfmt,
                                             input logic [1:0] stfmt);
    logic [3:0] size_s;
    if (we) begin
      case (stfmt)
        2'b00:   size_s = 4'd1;
        2'b01:   size_s = 4'd2;
        2'b10:   size_s = 4'd4;
        default: size_s = 4'd8;
      endcase
    end else begin
      case (ldfmt)
        3'b001:  size_s = 4'd2;
        3'b010:  size_s = 4'd4;
        3'b101:  size_s = 4'd8;
        default: size_s = 4'd1;
      endcase
    end
    return size_s;
  endfunction

  // 65-bit sum so an address near 2^64 cannot wrap into the legal window
  function automatic logic in_range(input logic [63:0] addr, input logic [3:0] size);
    logic [64:0] end_s;
    end_s = {1'b0, addr} + {61'd0, size};
    return (end_s <= 65'(ADDR_LIMIT));
  endfunction

  pri_e        state_q, state_d;
  logic        tie_s, gnt0_s, gnt1_s, xfer_s;
  logic        sel_we_s, sel_ok_s;
  logic [2:0]  sel_ldfmt_s;
  logic [1:0]  sel_stfmt_s;
  logic [63:0] sel_addr_s, sel_wdata_s;

  logic        rd_q, wr_q, err_q, lane_q;
  logic [63:0] addr_q, wdata_q;
  logic [2:0]  ldfmt_q;
  logic [1:0]  stfmt_q;
  logic        rsp_valid0_q, rsp_valid1_q, rsp_err0_q, rsp_err1_q;
  logic [63:0] rsp_data_q;
  logic [CNT_W-1:0] stall_q;

  assign tie_s  = bus.req0 & bus.req1;
  assign xfer_s = gnt0_s | gnt1_s;

  // Grants and priority next state; PRI1 only repays a lane 1 that lost a tie
  always_comb begin
    gnt0_s  = 1'b0;
    gnt1_s  = 1'b0;
    state_d = state_q;
    if (tie_s) begin
      if (state_q == PRI1) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b1;
      end
    end else begin
      gnt0_s = bus.req0;
      gnt1_s = bus.req1;
    end
    case (state_q)
      PRI0: begin
        if (gnt0_s && tie_s) state_d = PRI1;
        else                 state_d = PRI0;
      end
      PRI1: begin
        if (gnt1_s) state_d = PRI0;
        else        state_d = PRI1;
      end
      default: state_d = PRI0;
    endcase
  end

  // Winning lane's fields and their range check
  always_comb begin
    if (gnt1_s) begin
      sel_we_s    = bus.we1;
      sel_ldfmt_s = bus.ldfmt1;
      sel_stfmt_s = bus.stfmt1;
      sel_addr_s  = bus.addr1;
      sel_wdata_s = bus.wdata1;
    end else begin
      sel_we_s    = bus.we0;
      sel_ldfmt_s = bus.ldfmt0;
      sel_stfmt_s = bus.stfmt0;
      sel_addr_s  = bus.addr0;
      sel_wdata_s = bus.wdata0;
    end
    sel_ok_s = in_range(sel_addr_s, access_size(sel_we_s, sel_ldfmt_s, sel_stfmt_s));
  end

  // Priority state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PRI0;
    else        state_q <= state_d;
  end

  // Memory command register; address/data/formats hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      lane_q  <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      ldfmt_q <= 3'd0;
      stfmt_q <= 2'd0;
    end else if (xfer_s) begin
      rd_q    <= ~sel_we_s & sel_ok_s;
      wr_q    <= sel_we_s & sel_ok_s;
      err_q   <= ~sel_ok_s;
      lane_q  <= gnt1_s;
      addr_q  <= sel_addr_s;
      wdata_q <= sel_wdata_s;
      ldfmt_q <= sel_ldfmt_s;
      stfmt_q <= sel_stfmt_s;
    end else begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      err_q <= 1'b0;
    end
  end

  // Response stage: load data captured one edge after the command is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_err0_q   <= 1'b0;
      rsp_err1_q   <= 1'b0;
      rsp_data_q   <= 64'd0;
    end else begin
      rsp_valid0_q <= rd_q & ~lane_q;
      rsp_valid1_q <= rd_q & lane_q;
      rsp_err0_q   <= err_q & ~lane_q;
      rsp_err1_q   <= err_q & lane_q;
      if (rd_q) rsp_data_q <= bus.mem_rdata;
      else      rsp_data_q <= rsp_data_q;
    end
  end

  // Contention counter, sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (tie_s && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_q <= stall_q;
    end
  end

  assign bus.gnt0         = gnt0_s;
  assign bus.gnt1         = gnt1_s;
  assign bus.mem_read_en  = rd_q;
  assign bus.mem_write_en = wr_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.load_format  = ldfmt_q;
  assign bus.store_format = stfmt_q;
  assign bus.rsp_valid0   = rsp_valid0_q;
  assign bus.rsp_valid1   = rsp_valid1_q;
  assign bus.rsp_err0     = rsp_err0_q;
  assign bus.rsp_err1     = rsp_err1_q;
  assign bus.rsp_data     = rsp_data_q;
  assign stall_cnt        = stall_q;

endmodule
